// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - issuer/ROB-facing bundle of the rename-tracking register file
interface register_file_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  logic             rdy;
  logic             rename_valid;
  logic [4:0]       rename_reg;
  logic [TAG_W-1:0] rename_tag;
  logic [4:0]       check1;
  logic [4:0]       check2;
  logic [XLEN-1:0]  val1;
  logic [XLEN-1:0]  val2;
  logic [TAG_W-1:0] dep1;
  logic [TAG_W-1:0] dep2;
  logic             has_dep1;
  logic             has_dep2;
  logic             commit_valid;
  logic [4:0]       commit_reg;
  logic [TAG_W-1:0] commit_tag;
  logic [XLEN-1:0]  commit_value;
  logic             flush;

  modport master (
    output rdy, rename_valid, rename_reg, rename_tag, check1, check2,
           commit_valid, commit_reg, commit_tag, commit_value, flush,
    input  val1, val2, dep1, dep2, has_dep1, has_dep2
  );

  modport slave (
    input  rdy, rename_valid, rename_reg, rename_tag, check1, check2,
           commit_valid, commit_reg, commit_tag, commit_value, flush,
    output val1, val2, dep1, dep2, has_dep1, has_dep2
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename-tag tracking and commit bypass
module register_file #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input logic             clk,
  input logic             rst,
  register_file_if.slave  bus
);
  logic [XLEN-1:0]  value [32];
  logic [TAG_W-1:0] tag   [32];
  logic [31:0]      busy;

  wire commit_ok = bus.rdy && bus.commit_valid && (bus.commit_reg != 5'd0);
  wire rename_ok = bus.rdy && bus.rename_valid && !bus.flush && (bus.rename_reg != 5'd0);
  wire commit_hit = busy[bus.commit_reg] && (tag[bus.commit_reg] == bus.commit_tag);

  // Later assignments win: rename overrides the commit's busy clear on the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        value[i] <= '0;
        tag[i]   <= '0;
      end
      busy <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        for (int i = 0; i < 32; i++) tag[i] <= '0;
        busy <= '0;
      end
      if (commit_ok) begin
        value[bus.commit_reg] <= bus.commit_value;
        if (commit_hit) begin
          busy[bus.commit_reg] <= 1'b0;
          tag[bus.commit_reg]  <= '0;
        end
      end
      if (rename_ok) begin
        busy[bus.rename_reg] <= 1'b1;
        tag[bus.rename_reg]  <= bus.rename_tag;
      end
    end
  end

  function automatic logic [XLEN+TAG_W:0] lookup(
    input logic [4:0]       chk,
    input logic [XLEN-1:0]  v,
    input logic [TAG_W-1:0] t,
    input logic             b,
    input logic             cv,
    input logic [4:0]       cr,
    input logic [TAG_W-1:0] ct,
    input logic [XLEN-1:0]  cval
  );
    if (chk == 5'd0)
      return '0;
    // Commit bypass ignores rdy so the issuer never latches a tag being freed.
    else if (cv && (cr == chk) && b && (t == ct))
      return {cval, {TAG_W{1'b0}}, 1'b0};
    else
      return {v, (b ? t : {TAG_W{1'b0}}), b};
  endfunction

  assign {bus.val1, bus.dep1, bus.has_dep1} =
    lookup(bus.check1, value[bus.check1], tag[bus.check1], busy[bus.check1],
           bus.commit_valid, bus.commit_reg, bus.commit_tag, bus.commit_value);

  assign {bus.val2, bus.dep2, bus.has_dep2} =
    lookup(bus.check2, value[bus.check2], tag[bus.check2], busy[bus.check2],
           bus.commit_valid, bus.commit_reg, bus.commit_tag, bus.commit_value);
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  register_file_if #(.XLEN(32), .TAG_W(6)) bus ();

  register_file #(.XLEN(32), .TAG_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rename_valid = 1'b0;
    bus.commit_valid = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic port1(input string name, input logic [31:0] v, input logic [31:0] d, input logic [31:0] h);
    #1;
    chk({name, ".val1"}, bus.val1, v);
    chk({name, ".dep1"}, 32'(bus.dep1), d);
    chk({name, ".has1"}, 32'(bus.has_dep1), h);
  endtask

  task automatic port2(input string name, input logic [31:0] v, input logic [31:0] d, input logic [31:0] h);
    #1;
    chk({name, ".val2"}, bus.val2, v);
    chk({name, ".dep2"}, 32'(bus.dep2), d);
    chk({name, ".has2"}, 32'(bus.has_dep2), h);
  endtask

  task automatic rename(input logic [4:0] r, input logic [5:0] t);
    bus.rename_valid = 1'b1;
    bus.rename_reg   = r;
    bus.rename_tag   = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [5:0] t, input logic [31:0] v);
    bus.commit_valid = 1'b1;
    bus.commit_reg   = r;
    bus.commit_tag   = t;
    bus.commit_value = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.rename_valid = 1'b0;
    bus.rename_reg = '0;
    bus.rename_tag = '0;
    bus.commit_valid = 1'b0;
    bus.commit_reg = '0;
    bus.commit_tag = '0;
    bus.commit_value = '0;
    bus.flush = 1'b0;
    bus.check1 = 5'd0;
    bus.check2 = 5'd0;
    tick();
    tick();
    rst = 1'b0;

    port1("rst_x0", 0, 0, 0);
    port2("rst_x0", 0, 0, 0);
    bus.check1 = 5'd5;
    bus.check2 = 5'd0;
    port1("rst_x5", 0, 0, 0);
    port2("rst_x0b", 0, 0, 0);

    // rename x5 -> 12, then commit with bypass
    rename(5'd5, 6'd12);
    tick();
    idle();
    port1("ren_x5", 0, 12, 1);
    commit(5'd5, 6'd12, 32'hDEADBEEF);
    port1("byp_x5", 32'hDEADBEEF, 0, 0);
    tick();
    idle();
    port1("com_x5", 32'hDEADBEEF, 0, 0);

    // younger rename owns x7; stale commit must not clear it
    rename(5'd7, 6'd3);
    tick();
    rename(5'd7, 6'd9);
    tick();
    idle();
    bus.check1 = 5'd7;
    commit(5'd7, 6'd3, 32'h11);
    port1("nobyp_x7", 0, 9, 1);
    tick();
    idle();
    port1("stale_x7", 32'h11, 9, 1);

    // same-cycle rename and matching commit on x4
    rename(5'd4, 6'd15);
    tick();
    rename(5'd4, 6'd20);
    commit(5'd4, 6'd15, 32'h55);
    bus.check2 = 5'd4;
    port2("rc_byp_x4", 32'h55, 0, 0);
    tick();
    idle();
    port2("rc_x4", 32'h55, 20, 1);

    // flush with concurrent commit and rename
    rename(5'd1, 6'd1);
    tick();
    rename(5'd2, 6'd2);
    tick();
    rename(5'd3, 6'd3);
    tick();
    bus.flush = 1'b1;
    commit(5'd1, 6'd1, 32'hAA);
    rename(5'd6, 6'd4);
    bus.check1 = 5'd2;
    port1("pre_flush_x2", 0, 2, 1);
    tick();
    idle();
    bus.check1 = 5'd1;
    bus.check2 = 5'd6;
    port1("fl_x1", 32'hAA, 0, 0);
    port2("fl_x6", 0, 0, 0);
    bus.check1 = 5'd3;
    bus.check2 = 5'd7;
    port1("fl_x3", 0, 0, 0);
    port2("fl_x7", 32'h11, 0, 0);
    bus.check1 = 5'd4;
    port1("fl_x4", 32'h55, 0, 0);

    // rdy low: no state changes, x0 stays zero
    bus.rdy = 1'b0;
    rename(5'd8, 6'd30);
    commit(5'd8, 6'd30, 32'h77);
    tick();
    rename(5'd0, 6'd5);
    commit(5'd0, 6'd5, 32'h99);
    bus.check1 = 5'd0;
    port1("rdy0_x0", 0, 0, 0);
    tick();
    idle();
    bus.rdy = 1'b1;
    bus.check1 = 5'd8;
    bus.check2 = 5'd0;
    port1("rdy0_x8", 0, 0, 0);
    port2("rdy0_x0b", 0, 0, 0);

    // x0 ignored with rdy high
    rename(5'd0, 6'd7);
    commit(5'd0, 6'd7, 32'h1234);
    tick();
    idle();
    port2("x0_rdy1", 0, 0, 0);

    // bypass works while rdy is low but state holds
    rename(5'd9, 6'd7);
    tick();
    idle();
    bus.rdy = 1'b0;
    commit(5'd9, 6'd7, 32'h33);
    bus.check1 = 5'd9;
    port1("byp_rdy0_x9", 32'h33, 0, 0);
    tick();
    idle();
    bus.rdy = 1'b1;
    port1("hold_x9", 0, 7, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/register_file.md
# register_file

Architectural register file with rename-tag tracking for the out-of-order core. Sits directly downstream of the instruction issuer: it takes the issuer's per-instruction rename (destination register → ROB index) and serves its two combinational source-operand lookups (value, pending tag, pending flag). The ROB commit port retires values into it, and a CDB flush drops all pending renames.

## Interface
- XLEN, 32, data width
- TAG_W, 6, ROB index width (64-entry ROB)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, no state changes
- rename_valid  in  1  issuer renames a destination this cycle
- rename_reg  in  5  destination architectural register
- rename_tag  in  TAG_W  ROB index now owning rename_reg
- check1, check2  in  5  source register lookups
- val1, val2  out  XLEN  register value or bypassed commit value
- dep1, dep2  out  TAG_W  pending ROB tag; 0 when no dependency
- has_dep1, has_dep2  out  1  register awaits an uncommitted producer
- commit_valid  in  1  ROB retires an instruction with register result
- commit_reg  in  5  retiring destination
- commit_tag  in  TAG_W  ROB index of the retiring instruction
- commit_value  in  XLEN  retiring result
- flush  in  1  misprediction flush

## Operation
- State: per-register value[31:0], tag[TAG_W-1:0], busy bit, for 32 registers.
- x0: value, tag and busy are always 0. Renames and commits to x0 are ignored. Lookups of x0 return val=0, dep=0, has_dep=0.
- Commit, when commit_valid && rdy && commit_reg≠0:
  - value[commit_reg] ← commit_value, unconditionally.
  - If busy[commit_reg] && tag[commit_reg]==commit_tag, clear busy and set tag to 0.
  - A tag mismatch means a younger rename owns the register, so busy and tag are kept.
- Rename, when rename_valid && rdy && !flush && rename_reg≠0: tag ← rename_tag, busy ← 1.
- Same register, same cycle, commit and rename: the value is written and the rename wins (busy=1, tag=rename_tag).
- Flush, when flush && rdy:
  - All busy bits and tags are cleared.
  - A concurrent commit still writes its value, because the committing instruction is older than the flush.
  - A concurrent rename is dropped.
- rdy low: all inputs are ignored and state holds. Lookups remain live.
- Lookups are combinational per port (port 1 shown; port 2 identical):
  - If check1==0, output zeros.
  - Else if commit_valid && commit_reg==check1 && busy && tag==commit_tag:
    - val1=commit_value, has_dep1=0, dep1=0.
    - This same-cycle commit bypass applies regardless of rdy, so the issuer never captures a tag the ROB is freeing.
  - Else val1=value, dep1=(busy ? tag : 0), has_dep1=busy.
- Lookups never bypass a same-cycle rename. The issuer handles back-to-back renames itself.
- The wrap of rename_tag 63→0 needs no special handling. A tag is unique while busy.

## Timing
- Reset (rst high at posedge, regardless of rdy): all values, tags and busy bits become 0. With check inputs at 0 after reset, every output is 0.
- Rename and commit become visible at the lookup outputs on the cycle after the capturing posedge.
- Lookup latency is 0 cycles (combinational from check*, commit_*, and state).
- Flush takes effect at the next posedge. Lookups in the flush cycle still show pre-flush busy state.
- rst has priority over flush, flush over rename; commit is independent of flush.

## Test plan
- Reset, then look up x5 and x0:
  - required: val=0, dep=0, has_dep=0 on both ports.
- Rename x5→tag 12; next cycle look up x5:
  - required: has_dep1=1, dep1=12.
  - Then commit x5/tag 12/0xDEADBEEF. In that same cycle, check1=x5 returns val1=0xDEADBEEF, has_dep1=0 (bypass). The next cycle shows the same values from state.
- Rename x7→3, then x7→9, then commit x7/tag 3/0x11:
  - required: value=0x11, still has_dep=1 with dep=9.
  - Same cycle as the commit, the bypass must NOT fire (tag mismatch): has_dep=1, dep=9.
- Same cycle, rename x4→20 and commit x4 with its current tag and value 0x55:
  - required next cycle: val=0x55, has_dep=1, dep=20.
- Rename x1, x2, x3 to tags 1, 2, 3; then flush together with commit x1/tag 1/0xAA and rename x6→4:
  - required next cycle: all has_dep=0, x1 value 0xAA, x6 not busy.
- With rdy=0, apply a rename and a commit to x8, and rename/commit to x0:
  - required: x8 state unchanged when rdy returns.
  - x0 always reads 0 with no dependency.
